// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor: operands and start in,
// busy/done status and the registered result out.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell and a borrow flop.
// Result, borrow-out and signed overflow update only on the completion edge.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_load;
    logic             w_shift;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_d;
    logic             w_brw_next;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell on the current LSBs
    assign w_d        = r_a_sh[0] ^ r_b_sh[0] ^ r_brw;
    assign w_brw_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_brw);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_shift = 1'b1;
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_res  <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_load) begin
            r_a_sh <= bus.a;
            r_b_sh <= bus.b;
            r_brw  <= bus.bin;
            r_cnt  <= '0;
            r_sa   <= bus.a[WIDTH-1];
            r_sb   <= bus.b[WIDTH-1];
        end else if (w_shift) begin
            r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res  <= w_res_next;
            r_brw  <= w_brw_next;
            r_cnt  <= r_cnt + CW'(1);
            // Publish only once the last bit has been formed
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_brw_next;
                r_ovf  <= (r_sa != r_sb) && (w_res_next[WIDTH-1] != r_sa);
            end
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8 and WIDTH=16 against an arithmetic
// reference model; directed cases plus randomized operands.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  bus8 ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    // Reference: plain integer arithmetic on the unsigned and signed views.
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit bin, output longint unsigned d, output bit bo, output bit ov);
        longint unsigned m;
        longint sa, sb, sd, smax, smin;
        m    = (64'd1 << w) - 1;
        d    = (a - b - longint'(bin)) & m;
        bo   = (a < b + longint'(bin));
        sa   = ((a >> (w - 1)) & 1) != 0 ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = ((b >> (w - 1)) & 1) != 0 ? longint'(b) - (longint'(1) << w) : longint'(b);
        sd   = sa - sb - longint'(bin);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        ov   = (sd > smax) || (sd < smin);
    endfunction

    // One operation on the 8-bit DUT; scrambles operands right after acceptance.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output logic ov,
                        output int lat, output int busyc, output int donec);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
        lat = -1; busyc = 0; donec = 0; d = '0; bo = 1'b0; ov = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!bus8.busy) break;
            busyc++;
            if (bus8.done) begin
                donec++;
                if (lat < 0) begin
                    lat = i; d = bus8.diff; bo = bus8.bout; ov = bus8.ovf;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus8.start = 0;  bus8.a = 0;  bus8.b = 0;  bus8.bin = 0;
        bus16.start = 0; bus16.a = 0; bus16.b = 0; bus16.bin = 0;
        rst = 1'b1;
        #12;
        tests++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.bout, bus8.ovf} !== 12'h0) begin
            fails++;
            $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout, bus8.ovf);
        end
        tests++;
        if ({bus16.busy, bus16.done, bus16.diff, bus16.bout, bus16.ovf} !== 20'h0) begin
            fails++;
            $display("FAIL reset16: got busy=%b done=%b diff=%h, expected all 0",
                     bus16.busy, bus16.done, bus16.diff);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_directed();
        logic [7:0] ta [6] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F, 8'h00};
        logic [7:0] tb [6] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF, 8'hFF};
        logic       tn [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] td [6] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80, 8'h00};
        logic       tbo[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       tov[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] d; logic bo, ov; int lat, busyc, donec;
        for (int k = 0; k < 6; k++) begin
            run8(ta[k], tb[k], tn[k], d, bo, ov, lat, busyc, donec);
            tests++;
            if (lat !== 8 || busyc !== 9 || donec !== 1) begin
                fails++;
                $display("FAIL timing%0d: got latency=%0d busy_cycles=%0d dones=%0d, expected 8/9/1",
                         k, lat, busyc, donec);
            end
            tests++;
            if ({d, bo, ov} !== {td[k], tbo[k], tov[k]}) begin
                fails++;
                $display("FAIL result%0d: got diff=%h bout=%b ovf=%b, expected diff=%h bout=%b ovf=%b",
                         k, d, bo, ov, td[k], tbo[k], tov[k]);
            end
            tests++;
            if (bus8.diff !== td[k]) begin
                fails++;
                $display("FAIL hold%0d: got diff=%h after done, expected %h", k, bus8.diff, td[k]);
            end
            $display("[TB] directed %h-%h-%b -> diff=%h bout=%b ovf=%b lat=%0d",
                     ta[k], tb[k], tn[k], d, bo, ov, lat);
        end
    endtask

    task automatic test_start_while_busy();
        int donec = 0; int ended = 0; logic [7:0] d = '0;
        @(negedge clk);
        bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 0; bus8.start = 1;
        @(negedge clk);
        bus8.start = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus8.busy) begin ended = 1; break; end
            if (bus8.done) begin donec++; d = bus8.diff; end
            if (i == 2) begin bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1; end
            if (i == 3) bus8.start = 0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (d !== 8'h0F || donec !== 1 || ended !== 1 || bus8.busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_start: got diff=%h dones=%0d ended=%0d busy=%b, expected 0f/1/1/0",
                     d, donec, ended, bus8.busy);
        end
        $display("[TB] start while busy: diff=%h dones=%0d", d, donec);
    endtask

    task automatic test_back_to_back();
        int idx[$]; int bad = 0; int waited = 0;
        @(negedge clk);
        bus8.a = 8'h33; bus8.b = 8'h11; bus8.bin = 0; bus8.start = 1;
        @(negedge clk);
        for (int i = 0; i < 45; i++) begin
            if (bus8.done) begin
                idx.push_back(i);
                if (bus8.diff !== 8'h22) bad++;
            end
            @(negedge clk);
        end
        bus8.start = 0;
        while (bus8.busy && waited < 20) begin @(negedge clk); waited++; end
        tests++;
        if (idx.size() !== 4 || bad !== 0) begin
            fails++;
            $display("FAIL b2b_count: got %0d dones (%0d bad diffs), expected 4 dones all 22",
                     idx.size(), bad);
        end
        for (int j = 1; j < idx.size(); j++) begin
            tests++;
            if (idx[j] - idx[j-1] !== 10) begin
                fails++;
                $display("FAIL b2b_period: got %0d cycles, expected 10", idx[j] - idx[j-1]);
            end
        end
        tests++;
        if (bus8.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: got busy=%b, expected 0", bus8.busy);
        end
        $display("[TB] back-to-back: %0d dones", idx.size());
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic bo, ov; int lat, busyc, donec; int spurious = 0;
        run8(8'h10, 8'h01, 1'b0, d, bo, ov, lat, busyc, donec);
        @(negedge clk);
        bus8.a = 8'h20; bus8.b = 8'h01; bus8.bin = 0; bus8.start = 1;
        @(negedge clk);
        bus8.start = 0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.bout, bus8.ovf} !== 12'h0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b diff=%h bout=%b ovf=%b, expected all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout, bus8.ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done || bus8.busy) spurious++;
            @(negedge clk);
        end
        tests++;
        if (spurious !== 0) begin
            fails++;
            $display("FAIL reset_abort: got %0d busy/done cycles after abort, expected 0", spurious);
        end
        run8(8'h09, 8'h04, 1'b0, d, bo, ov, lat, busyc, donec);
        tests++;
        if ({d, bo, donec} !== {8'h05, 1'b0, 32'd1}) begin
            fails++;
            $display("FAIL reset_after: got diff=%h bout=%b dones=%0d, expected 05/0/1", d, bo, donec);
        end
        $display("[TB] reset mid-op: recovered diff=%h", d);
    endtask

    task automatic test_random8(input int n);
        logic [7:0] a, b; logic bin; longint unsigned ed; bit ebo, eov;
        int total_done = 0; int errs = 0;
        for (int k = 0; k < n; k++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            if (k % 7 == 0) b = 8'hFF;
            model(8, longint'(a), longint'(b), bin, ed, ebo, eov);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1;
            @(negedge clk);
            for (int i = 0; i < 40; i++) begin
                if (!bus8.busy) break;
                if (bus8.done) begin
                    total_done++;
                    tests++;
                    if ({bus8.diff, bus8.bout, bus8.ovf} !== {ed[7:0], ebo, eov} || i !== 8) begin
                        fails++; errs++;
                        $display("FAIL rand8: %h-%h-%b got diff=%h bout=%b ovf=%b at %0d, expected %h/%b/%b at 8",
                                 a, b, bin, bus8.diff, bus8.bout, bus8.ovf, i, ed[7:0], ebo, eov);
                    end
                end
                bus8.start = 1'($urandom);
                bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
                @(negedge clk);
            end
            bus8.start = 0;
        end
        tests++;
        if (total_done !== n) begin
            fails++;
            $display("FAIL rand8_count: got %0d dones, expected %0d", total_done, n);
        end
        $display("[TB] random WIDTH=8: %0d ops, %0d errors", n, errs);
    endtask

    task automatic test_random16(input int n);
        logic [15:0] a, b; logic bin; longint unsigned ed; bit ebo, eov;
        int total_done = 0; int errs = 0;
        for (int k = 0; k < n; k++) begin
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            if (k % 7 == 0) b = 16'hFFFF;
            model(16, longint'(a), longint'(b), bin, ed, ebo, eov);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus16.a = a; bus16.b = b; bus16.bin = bin; bus16.start = 1;
            @(negedge clk);
            for (int i = 0; i < 60; i++) begin
                if (!bus16.busy) break;
                if (bus16.done) begin
                    total_done++;
                    tests++;
                    if ({bus16.diff, bus16.bout, bus16.ovf} !== {ed[15:0], ebo, eov} || i !== 16) begin
                        fails++; errs++;
                        $display("FAIL rand16: %h-%h-%b got diff=%h bout=%b ovf=%b at %0d, expected %h/%b/%b at 16",
                                 a, b, bin, bus16.diff, bus16.bout, bus16.ovf, i, ed[15:0], ebo, eov);
                    end
                end
                bus16.start = 1'($urandom);
                bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.bin = 1'($urandom);
                @(negedge clk);
            end
            bus16.start = 0;
        end
        tests++;
        if (total_done !== n) begin
            fails++;
            $display("FAIL rand16_count: got %0d dones, expected %0d", total_done, n);
        end
        $display("[TB] random WIDTH=16: %0d ops, %0d errors", n, errs);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random8(1000);
        test_random16(1000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
